// File: rtl/mpc_h_vec_builder.sv
// rtl/mpc_h_vec_builder.sv - computes h = F*x row by row from a coefficient ROM
// and writes each saturated row result into the h vector RAM.
module mpc_h_vec_builder #(
  parameter int DW    = 21,
  parameter int CW    = 18,
  parameter int SHIFT = 12,
  parameter int NX    = 4,
  parameter int NROWS = 18,
  parameter int AW    = 5,
  parameter int FAW   = 7,
  parameter int ACC_W = 44
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NX*DW-1:0] x_in,
  output logic             busy,
  output logic             done,
  output logic             sat_flag,
  output logic [FAW-1:0]   f_address,
  output logic             f_ce,
  input  logic [CW-1:0]    f_q,
  output logic [AW-1:0]    h_address0,
  output logic             h_ce0,
  output logic             h_we0,
  output logic [DW-1:0]    h_d0
);

  localparam int COLW = (NX > 1) ? $clog2(NX) : 1;
  localparam logic signed [ACC_W-1:0] H_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] H_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, RD, ACC, WR, DONE} state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            row_q, row_d;
  logic [COLW-1:0]          col_q, col_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [NX*DW-1:0]         x_q, x_d;
  logic                     sat_q, sat_d;

  logic [COLW-1:0]          x_idx;
  logic [DW-1:0]            x_sel;
  logic signed [ACC_W-1:0]  x_ext, f_ext, prod, shifted;
  logic                     clip_hi, clip_lo;
  logic [DW-1:0]            h_val;

  // The ROM answers one cycle late, so each cycle multiplies the previous column.
  always_comb begin
    x_idx = (state_q == ACC) ? COLW'(NX - 1) : col_q - 1'b1;
    x_sel = '0;
    for (int j = 0; j < NX; j++) begin
      if (x_idx == COLW'(j)) x_sel = x_q[j*DW +: DW];
    end
    x_ext   = {{(ACC_W-DW){x_sel[DW-1]}}, x_sel};
    f_ext   = {{(ACC_W-CW){f_q[CW-1]}}, f_q};
    prod    = x_ext * f_ext;
    shifted = acc_q >>> SHIFT;
    clip_hi = shifted > H_MAX;
    clip_lo = shifted < H_MIN;
    if (clip_hi)      h_val = {1'b0, {(DW-1){1'b1}}};
    else if (clip_lo) h_val = {1'b1, {(DW-1){1'b0}}};
    else              h_val = shifted[DW-1:0];
  end

  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    sat_flag   = sat_q;
    f_ce       = (state_q == RD);
    f_address  = f_ce ? (FAW'(row_q) * FAW'(NX) + FAW'(col_q)) : '0;
    h_ce0      = (state_q == WR);
    h_we0      = (state_q == WR);
    h_address0 = (state_q == WR) ? row_q : '0;
    h_d0       = (state_q == WR) ? h_val : '0;
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = acc_q;
    x_d     = x_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x_in;
          sat_d   = 1'b0;
          row_d   = '0;
          col_d   = '0;
          acc_d   = '0;
          state_d = RD;
        end
      end
      RD: begin
        acc_d = (col_q == '0) ? '0 : acc_q + prod;
        if (col_q == COLW'(NX - 1)) begin
          col_d   = '0;
          state_d = ACC;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      ACC: begin
        acc_d   = acc_q + prod;
        state_d = WR;
      end
      WR: begin
        sat_d = sat_q | clip_hi | clip_lo;
        if (row_q == AW'(NROWS - 1)) begin
          state_d = DONE;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_mpc_h_vec_builder.sv
// tb/tb_mpc_h_vec_builder.sv - directed and randomized runs against a
// row-by-row arithmetic model of h = sat((F*x) >>> 12).
module tb_mpc_h_vec_builder;

  localparam int DW = 21, CW = 18, NX = 4, NROWS = 18, AW = 5, FAW = 7;
  localparam longint HMAX = 1048575, HMIN = -1048576;

  logic             clk = 1'b0;
  logic             reset, start;
  logic [NX*DW-1:0] x_in;
  logic             busy, done, sat_flag, f_ce, h_ce0, h_we0;
  logic [FAW-1:0]   f_address;
  logic [CW-1:0]    f_q;
  logic [AW-1:0]    h_address0;
  logic [DW-1:0]    h_d0;

  mpc_h_vec_builder dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in),
    .busy(busy), .done(done), .sat_flag(sat_flag),
    .f_address(f_address), .f_ce(f_ce), .f_q(f_q),
    .h_address0(h_address0), .h_ce0(h_ce0), .h_we0(h_we0), .h_d0(h_d0)
  );

  always #5 clk = ~clk;

  logic signed [CW-1:0] f_mem [NROWS*NX];
  logic signed [DW-1:0] h_mem [NROWS];
  int cyc = 0, base = 0, wr_total = 0, done_total = 0, done_cyc = -1;
  int fce_total = 0, hce_total = 0;
  int wlog_addr [1024];
  int wlog_cyc  [1024];

  int     xv [NX];
  longint exp_h [NROWS];
  longint prev_h [NROWS];
  bit     exp_sat;
  int     n_vec = 0, n_err = 0;
  int     wr0, dn0, fc0, hc0;

  // Synchronous ROM with one-cycle latency.
  always @(posedge clk) begin
    if (f_ce) f_q <= f_mem[int'(f_address)];
  end

  // RAM model plus write/done/enable bookkeeping; cycle index is relative to the run base.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (f_ce) fce_total <= fce_total + 1;
    if (h_ce0) hce_total <= hce_total + 1;
    if (h_ce0 && h_we0) begin
      h_mem[int'(h_address0)] <= h_d0;
      wlog_addr[wr_total] <= int'(h_address0);
      wlog_cyc[wr_total]  <= cyc - base;
      wr_total <= wr_total + 1;
    end
    if (done) begin
      done_total <= done_total + 1;
      done_cyc   <= cyc - base;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void compute_model();
    longint s, sh;
    exp_sat = 1'b0;
    for (int r = 0; r < NROWS; r++) begin
      s = 0;
      for (int c = 0; c < NX; c++) s += longint'(f_mem[r*NX+c]) * longint'(xv[c]);
      sh = s >>> 12;
      if (sh > HMAX) begin sh = HMAX; exp_sat = 1'b1; end
      else if (sh < HMIN) begin sh = HMIN; exp_sat = 1'b1; end
      exp_h[r] = sh;
    end
  endfunction

  task automatic clear_f();
    for (int k = 0; k < NROWS*NX; k++) f_mem[k] = '0;
  endtask

  task automatic rand_f(input int fmax);
    int v;
    for (int k = 0; k < NROWS*NX; k++) begin
      v = int'($urandom_range(2*fmax, 0)) - fmax;
      f_mem[k] = v[CW-1:0];
    end
  endtask

  task automatic rand_x(input int xmax);
    for (int j = 0; j < NX; j++) xv[j] = int'($urandom_range(2*xmax, 0)) - xmax;
  endtask

  // Entered at a negedge (cycle 0 of the new run); leaves at the negedge of cycle 1.
  task automatic start_run();
    compute_model();
    chk("idle_busy", busy, 0);
    for (int j = 0; j < NX; j++) x_in[j*DW +: DW] = xv[j][DW-1:0];
    start = 1'b1;
    base = cyc;
    wr0 = wr_total; dn0 = done_total; fc0 = fce_total; hc0 = hce_total;
    @(negedge clk);
    start = 1'b0;
    chk("c1_busy", busy, 1);
    chk("c1_f_ce", f_ce, 1);
    chk("c1_f_address", f_address, 0);
    chk("c1_sat_cleared", sat_flag, 0);
  endtask

  task automatic wait_until(input int k);
    while (cyc - base < k) @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_total == dn0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", done_total - dn0, 1);
  endtask

  task automatic check_run(input string name);
    chk({name, "_writes"}, wr_total - wr0, NROWS);
    chk({name, "_h_ce_cycles"}, hce_total - hc0, NROWS);
    chk({name, "_f_ce_cycles"}, fce_total - fc0, NROWS*NX);
    chk({name, "_done_count"}, done_total - dn0, 1);
    chk({name, "_done_cycle"}, done_cyc, 109);
    chk({name, "_sat_flag"}, sat_flag, exp_sat);
    for (int i = 0; i < NROWS; i++) begin
      chk($sformatf("%s_waddr%0d", name, i), wlog_addr[wr0+i], i);
      chk($sformatf("%s_wcyc%0d", name, i), wlog_cyc[wr0+i], 6*(i+1));
      chk($sformatf("%s_h%0d", name, i), longint'(h_mem[i]), exp_h[i]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; x_in = '0;
    clear_f();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_f_ce", f_ce, 0);
    chk("rst_h_ce0", h_ce0, 0);
    chk("rst_h_we0", h_we0, 0);
    chk("rst_f_address", f_address, 0);
    chk("rst_h_address0", h_address0, 0);
    chk("rst_h_d0", h_d0, 0);
    reset = 1'b0;
    @(negedge clk);

    clear_f();
    for (int i = 0; i < NX; i++) f_mem[i*NX+i] = 18'sd4096;
    xv = '{100, -200, 300, -400};
    start_run(); wait_done(); check_run("ident");
    chk("ident_h1", longint'(h_mem[1]), -200);
    chk("ident_h3", longint'(h_mem[3]), -400);

    clear_f();
    f_mem[20] = 18'sd2048; f_mem[21] = -18'sd4096; f_mem[22] = 18'sd1024; f_mem[23] = 18'sd8192;
    xv = '{400, 100, -800, 50};
    start_run(); wait_done(); check_run("mixA");
    chk("mix_h5", longint'(h_mem[5]), 0);

    clear_f();
    for (int c = 0; c < NX; c++) f_mem[24+c] = 18'sd4096;
    xv = '{1, 2, 3, 4};
    start_run(); wait_done(); check_run("mixB");
    chk("mix_h6", longint'(h_mem[6]), 10);

    clear_f();
    f_mem[0] = 18'sd1;
    xv = '{-1, 0, 0, 0};
    start_run(); wait_done(); check_run("floor_neg");
    chk("floor_neg_h0", longint'(h_mem[0]), -1);
    xv = '{1, 0, 0, 0};
    start_run(); wait_done(); check_run("floor_pos");
    chk("floor_pos_h0", longint'(h_mem[0]), 0);

    for (int k = 0; k < NROWS*NX; k++) f_mem[k] = 18'sd131071;
    xv = '{1048575, 1048575, 1048575, 1048575};
    start_run(); wait_done(); check_run("sat_pos");
    chk("sat_pos_h0", longint'(h_mem[0]), HMAX);
    repeat (5) @(negedge clk);
    chk("sat_sticky", sat_flag, 1);
    xv = '{-1048576, -1048576, -1048576, -1048576};
    start_run(); wait_done(); check_run("sat_neg");
    chk("sat_neg_h17", longint'(h_mem[17]), HMIN);

    rand_f(4096); rand_x(200000);
    start_run();
    wait_until(20);
    x_in = {$urandom, $urandom, $urandom};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(109);
    chk("hs_done_109", done, 1);
    x_in = {$urandom, $urandom, $urandom};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hs_idle_110_busy", busy, 0);
    chk("hs_idle_110_f_ce", f_ce, 0);
    check_run("hs");
    rand_f(8192); rand_x(100000);
    start_run(); wait_done(); check_run("hs_next");

    for (int i = 0; i < NROWS; i++) prev_h[i] = exp_h[i];
    rand_f(16384); rand_x(50000);
    start_run();
    wait_until(40);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_f_ce", f_ce, 0);
    chk("mrst_h_we0", h_we0, 0);
    chk("mrst_h_ce0", h_ce0, 0);
    chk("mrst_f_address", f_address, 0);
    chk("mrst_h_address0", h_address0, 0);
    chk("mrst_h_d0", h_d0, 0);
    repeat (40) @(negedge clk);
    chk("mrst_writes", wr_total - wr0, 6);
    chk("mrst_no_done", done_total - dn0, 0);
    for (int i = 0; i < NROWS; i++)
      chk($sformatf("mrst_h%0d", i), longint'(h_mem[i]), (i < 6) ? exp_h[i] : prev_h[i]);

    rand_f(4096); rand_x(300000);
    start_run(); wait_done(); check_run("post_rst");

    rand_f(131072); rand_x(1048576);
    start_run(); wait_done(); check_run("rand_full");
    rand_f(2048); rand_x(1000);
    start_run(); wait_done(); check_run("rand_small");
    rand_f(40000); rand_x(400000);
    start_run(); wait_done(); check_run("rand_mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mpc_h_vec_builder.md
Name: mpc_h_vec_builder

Overview:
- Builds the MPC linear-term vector h = F·x each control period and writes it row by row into the h vector RAM (18 x 21-bit) through that RAM's write port (port 0).
- F coefficients come from an external synchronous ROM with 1-cycle read latency. The state vector x is latched on start.
- Sits directly upstream of the h RAM. The QP solver reads h through the RAM's read port only after done.

Parameters:
- DW, 21, data width of x and h (signed, same fixed-point format).
- CW, 18, F coefficient width (signed).
- SHIFT, 12, fractional bits of F; product is arithmetic-shifted right by SHIFT.
- NX, 4, state-vector length (columns of F).
- NROWS, 18, rows of F = h entries written.
- AW, 5, h RAM address width.
- FAW, 7, F ROM address width (must hold NROWS*NX).
- ACC_W, 44, accumulator width (≥ DW+CW+clog2(NX)).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- x_in  in  NX*DW  packed state vector, x[j] = x_in[j*DW +: DW], sampled with start.
- busy  out  1  high from the cycle after start is accepted until the DONE cycle, inclusive.
- done  out  1  one-cycle pulse after the last h row is written.
- sat_flag  out  1  sticky: set if any row saturated this run; cleared on start accept.
- f_address  out  FAW  ROM address = row*NX + col.
- f_ce  out  1  ROM read enable.
- f_q  in  CW  ROM data, valid the cycle after f_ce.
- h_address0  out  AW  h RAM address (row index).
- h_ce0  out  1  h RAM enable.
- h_we0  out  1  h RAM write enable.
- h_d0  out  DW  h RAM write data.

Behaviour:
- Reset (synchronous): state=IDLE; busy=0, done=0, sat_flag=0, f_ce=0, h_ce0=0, h_we0=0, f_address=0, h_address0=0, h_d0=0. Row/column counters and the accumulator are cleared.
- States: IDLE, RD, ACC, WR, DONE.
- IDLE: on start=1, latch x_in, clear sat_flag, row=0, col=0, go to RD. start=0 keeps IDLE.
- RD, NX cycles (col 0..NX-1): f_ce=1 and f_address=row*NX+col. In the same cycle, the product of f_q (returned for col-1) and x[col-1] is accumulated for col≥1. At col 0 the accumulator is loaded with 0. After col NX-1, go to ACC.
- ACC, 1 cycle: f_ce=0; add the final product f_q*x[NX-1]; go to WR.
- WR, 1 cycle: h_ce0=h_we0=1, h_address0=row, h_d0=sat(acc >>> SHIFT). Set sat_flag if clipped. If row=NROWS-1 go to DONE, else row+1 and go to RD.
- DONE, 1 cycle: done=1; go to IDLE.
- Arithmetic: product = signed DW × signed CW, full precision, sign-extended to ACC_W; accumulation is exact (no wrap). Result = arithmetic right shift by SHIFT (floor toward −inf), then saturate to [−2^(DW−1), 2^(DW−1)−1].
- Timing: row period = NX+2 cycles. With defaults, the start-accept edge is cycle 0. First RD is cycle 1, last WR is cycle NROWS*(NX+2)=108, done is high in cycle 109, and the next start can be accepted in cycle 110.
- h_ce0/h_we0 are high only in WR. f_ce is high only in RD. No other RAM or ROM access occurs.
- start while busy (RD/ACC/WR/DONE) is ignored, with no restart and no effect on latched x. x_in changes after acceptance have no effect.
- Reset mid-run returns to IDLE immediately with no done. Rows already written stay in the RAM. Unwritten rows keep their old values.
- sat_flag holds its value after done until the next accepted start or reset.

Test Plan:
- Identity: F[i][i]=4096 (1.0) for i<4, all other entries 0; x=[100,−200,300,−400] → writes h[0..3]=100,−200,300,−400 and h[4..17]=0. Exactly 18 writes, addresses 0..17 in order; done in cycle 109; sat_flag=0.
- Mixed row: row 5 F=[2048,−4096,1024,8192], x=[400,100,−800,50] → h[5]=200−100−200+100=0. Row 6 F=[4096,4096,4096,4096], x=[1,2,3,4] → h[6]=10.
- Floor/sign: F[0][0]=1, x0=−1, rest 0 → h[0]=−1. F[0][0]=1, x0=+1 → h[0]=0.
- Saturation: all F=131071, all x=1048575 → every h=1048575 and sat_flag=1. All x=−1048576 → every h=−1048576. sat_flag stays 1 after done and clears on the next start.
- Handshake: pulse start again in cycles 20 and 109 → ignored, with exactly 18 writes and one done. Start accepted in cycle 110 → new run whose first RD is in cycle 111.
- Reset in cycle 40 (row 6 in progress) → outputs go to their reset values in the next cycle, no done, no further writes. A subsequent start completes a full run normally.
